// File: rtl/vcmd_encoder_if.sv
// Pixel write request channel between host-side logic and the video command
// encoder: address + data byte with a valid/ready handshake.
interface vcmd_encoder_if #(
  parameter int AWIDTH = 18,
  parameter int DWIDTH = 8
);
  logic              WrValidIn;
  logic              WrReadyOut;
  logic [AWIDTH-1:0] WrAddrIn;
  logic [DWIDTH-1:0] WrDataIn;

  // Host side drives requests and observes ready.
  modport master (
    output WrValidIn,
    output WrAddrIn,
    output WrDataIn,
    input  WrReadyOut
  );

  // Encoder side consumes requests and drives ready.
  modport slave (
    input  WrValidIn,
    input  WrAddrIn,
    input  WrDataIn,
    output WrReadyOut
  );
endinterface

// File: rtl/vcmd_encoder.sv
// Transmit-side video command encoder. Collects contiguous pixel writes into
// a burst buffer and emits them as SetAddr (when the receiver's tracked write
// pointer does not already match) + Write1P + length + data bytes. Noop 0x00
// is emitted whenever no protocol byte is valid. All outputs are registered
// from next-state values so the first stream byte follows the trigger cycle.
module vcmd_encoder #(
  parameter int AWIDTH      = 18,
  parameter int DWIDTH      = 8,
  parameter int BURSTLEN    = 16,
  parameter int IDLETIMEOUT = 8
) (
  input  logic              ByteClkIn,
  input  logic              ResetIn,
  vcmd_encoder_if.slave     wr,
  input  logic              FlushIn,
  output logic [DWIDTH-1:0] ByteOut,
  output logic              ByteValidOut,
  output logic              BusyOut
);

  localparam int CW = (BURSTLEN > 1) ? $clog2(BURSTLEN) : 1;

  localparam logic [2:0] S_COLLECT = 3'd0;
  localparam logic [2:0] S_SADDR   = 3'd1;
  localparam logic [2:0] S_PAGE    = 3'd2;
  localparam logic [2:0] S_HIGH    = 3'd3;
  localparam logic [2:0] S_LOW     = 3'd4;
  localparam logic [2:0] S_WCMD    = 3'd5;
  localparam logic [2:0] S_LEN     = 3'd6;
  localparam logic [2:0] S_DATA    = 3'd7;

  localparam logic [CW:0] CNT_ZERO  = {(CW+1){1'b0}};
  localparam logic [CW:0] CNT_ONE   = {{CW{1'b0}}, 1'b1};
  localparam logic [CW:0] CNT_FULL  = (CW+1)'(BURSTLEN);
  localparam logic [7:0]  IDLE_LAST = 8'(IDLETIMEOUT - 1);

  logic [2:0]        state_q, state_d;
  logic [CW:0]       cnt_q, cnt_d;
  logic [7:0]        idle_q, idle_d;
  logic [CW-1:0]     idx_q, idx_d;
  logic [AWIDTH-1:0] run_addr_q, run_addr_d;
  logic [AWIDTH-1:0] track_addr_q, track_addr_d;
  logic              track_valid_q, track_valid_d;
  logic              ready_q, ready_d;
  logic [DWIDTH-1:0] byte_q, byte_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic [DWIDTH-1:0] buf_q [BURSTLEN];

  logic [AWIDTH-1:0] exp_addr_s;
  logic [31:0]       ra_ext_s;
  logic              in_collect_s, have_run_s, contig_s, accept_s;
  logic              noncontig_s, timeout_s, trigger_s, skip_s, last_s;

  // A request extends the run only if it lands exactly on RunAddr+Cnt (wrapping);
  // a non-contiguous request is left pending and closes the current run.
  assign exp_addr_s   = run_addr_q + AWIDTH'(cnt_q);
  assign ra_ext_s     = 32'(run_addr_q);
  assign in_collect_s = (state_q == S_COLLECT);
  assign have_run_s   = (cnt_q != CNT_ZERO);
  assign contig_s     = (wr.WrAddrIn == exp_addr_s);
  assign accept_s     = in_collect_s & wr.WrValidIn & ready_q & (~have_run_s | contig_s);
  assign noncontig_s  = in_collect_s & wr.WrValidIn & have_run_s & ~contig_s;
  assign timeout_s    = ~accept_s & (idle_q >= IDLE_LAST);
  assign trigger_s    = in_collect_s & have_run_s &
                        ((cnt_q == CNT_FULL) | noncontig_s | FlushIn | timeout_s);
  assign skip_s       = track_valid_q & (run_addr_q == track_addr_q);
  assign last_s       = ({1'b0, idx_q} == (cnt_q - CNT_ONE));

  assign wr.WrReadyOut = ready_q;
  assign ByteOut       = byte_q;
  assign ByteValidOut  = valid_q;
  assign BusyOut       = busy_q;

  // Next-state logic: run collection, flush decision and burst sequencing.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    idle_d        = idle_q;
    idx_d         = idx_q;
    run_addr_d    = run_addr_q;
    track_addr_d  = track_addr_q;
    track_valid_d = track_valid_q;
    case (state_q)
      S_COLLECT: begin
        if (accept_s) begin
          cnt_d  = cnt_q + CNT_ONE;
          idle_d = 8'd0;
          if (!have_run_s) begin
            run_addr_d = wr.WrAddrIn;
          end else begin
            run_addr_d = run_addr_q;
          end
        end else if (have_run_s) begin
          idle_d = idle_q + 8'd1;
        end else begin
          idle_d = 8'd0;
        end
        if (trigger_s) begin
          state_d = skip_s ? S_WCMD : S_SADDR;
        end else begin
          state_d = S_COLLECT;
        end
      end
      S_SADDR: state_d = S_PAGE;
      S_PAGE:  state_d = S_HIGH;
      S_HIGH:  state_d = S_LOW;
      S_LOW:   state_d = S_WCMD;
      S_WCMD:  state_d = S_LEN;
      S_LEN: begin
        state_d = S_DATA;
        idx_d   = {CW{1'b0}};
      end
      S_DATA: begin
        if (last_s) begin
          state_d       = S_COLLECT;
          cnt_d         = CNT_ZERO;
          idle_d        = 8'd0;
          track_addr_d  = exp_addr_s;
          track_valid_d = 1'b1;
        end else begin
          idx_d = idx_q + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      default: state_d = S_COLLECT;
    endcase
  end

  // Output byte for the state being entered, so outputs can be registered.
  always_comb begin
    byte_d  = 8'h00;
    valid_d = 1'b1;
    case (state_d)
      S_COLLECT: valid_d = 1'b0;
      S_SADDR:   byte_d  = 8'h01;
      S_PAGE:    byte_d  = ra_ext_s[23:16];
      S_HIGH:    byte_d  = ra_ext_s[15:8];
      S_LOW:     byte_d  = ra_ext_s[7:0];
      S_WCMD:    byte_d  = 8'h10;
      S_LEN:     byte_d  = 8'(cnt_d - CNT_ONE);
      S_DATA:    byte_d  = buf_q[idx_d];
      default: begin
        byte_d  = 8'h00;
        valid_d = 1'b0;
      end
    endcase
    busy_d  = (state_d != S_COLLECT);
    ready_d = (state_d == S_COLLECT) & (cnt_d != CNT_FULL);
  end

  // Control and output registers with synchronous reset; reset abandons any burst.
  always_ff @(posedge ByteClkIn) begin
    if (ResetIn) begin
      state_q       <= S_COLLECT;
      cnt_q         <= CNT_ZERO;
      idle_q        <= 8'd0;
      idx_q         <= {CW{1'b0}};
      run_addr_q    <= {AWIDTH{1'b0}};
      track_addr_q  <= {AWIDTH{1'b0}};
      track_valid_q <= 1'b0;
      ready_q       <= 1'b0;
      byte_q        <= 8'h00;
      valid_q       <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idle_q        <= idle_d;
      idx_q         <= idx_d;
      run_addr_q    <= run_addr_d;
      track_addr_q  <= track_addr_d;
      track_valid_q <= track_valid_d;
      ready_q       <= ready_d;
      byte_q        <= byte_d;
      valid_q       <= valid_d;
      busy_q        <= busy_d;
    end
  end

  // Burst data buffer; contents are only meaningful below Cnt, so no reset.
  always_ff @(posedge ByteClkIn) begin
    if (!ResetIn && accept_s) begin
      buf_q[cnt_q[CW-1:0]] <= wr.WrDataIn;
    end
  end

endmodule

// File: tb/tb_vcmd_encoder.sv
// Self-checking bench for vcmd_encoder: a host model tracks the run buffer and
// the receiver write pointer, pushes each expected burst onto a byte queue when
// the stimulus that triggers it is driven, and every cycle's output is compared
// against the queue head.
module tb_vcmd_encoder;
  localparam int AW = 18;
  localparam int BL = 16;
  localparam int IT = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic [7:0] byte_o;
  logic       bv;
  logic       busy;

  vcmd_encoder_if #(.AWIDTH(AW), .DWIDTH(8)) wr_if ();

  vcmd_encoder #(.AWIDTH(AW), .DWIDTH(8), .BURSTLEN(BL), .IDLETIMEOUT(IT)) dut (
    .ByteClkIn   (clk),
    .ResetIn     (rst),
    .wr          (wr_if),
    .FlushIn     (flush),
    .ByteOut     (byte_o),
    .ByteValidOut(bv),
    .BusyOut     (busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [7:0]    exp_q[$];
  logic [AW-1:0] m_run;
  logic [AW-1:0] m_track;
  logic          m_tv;
  int            m_cnt;
  logic [7:0]    m_buf[BL];

  // Advance one cycle, sample #1 after the edge and check the stream byte.
  task automatic tick();
    logic [7:0] e;
    @(posedge clk);
    #1;
    tests++;
    if (bv) begin
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL stream_extra: got byte %h, expected no valid byte", byte_o);
      end else begin
        e = exp_q.pop_front();
        if (byte_o !== e) begin
          fails++;
          $display("FAIL stream_byte: got %h, expected %h", byte_o, e);
        end
      end
    end else if (byte_o !== 8'h00) begin
      fails++;
      $display("FAIL noop_byte: got %h, expected 00", byte_o);
    end
  endtask

  // Push the burst the receiver should see for the current model run.
  task automatic model_flush();
    logic [31:0] a;
    a = 32'(m_run);
    if (!(m_tv && (m_run == m_track))) begin
      exp_q.push_back(8'h01);
      exp_q.push_back(a[23:16]);
      exp_q.push_back(a[15:8]);
      exp_q.push_back(a[7:0]);
    end
    exp_q.push_back(8'h10);
    exp_q.push_back(8'(m_cnt - 1));
    for (int i = 0; i < m_cnt; i++) exp_q.push_back(m_buf[i]);
    m_track = m_run + AW'(m_cnt);
    m_tv    = 1'b1;
    m_cnt   = 0;
  endtask

  // Present a request and hold it until the encoder takes it.
  task automatic write_byte(input logic [AW-1:0] a, input logic [7:0] d);
    logic          pre, acc, done;
    logic [AW-1:0] nxt;
    done = 1'b0;
    wr_if.WrValidIn = 1'b1;
    wr_if.WrAddrIn  = a;
    wr_if.WrDataIn  = d;
    for (int i = 0; i < 100 && !done; i++) begin
      pre = wr_if.WrReadyOut;
      nxt = m_run + AW'(m_cnt);
      acc = pre && ((m_cnt == 0) || (a == nxt));
      if (pre && !acc) model_flush();
      tick();
      if (acc) begin
        if (m_cnt == 0) m_run = a;
        m_buf[m_cnt] = d;
        m_cnt++;
        done = 1'b1;
        if (m_cnt == BL) model_flush();
      end
    end
    wr_if.WrValidIn = 1'b0;
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL write_accept: addr %h not accepted within 100 cycles", a);
    end
  endtask

  task automatic flush_pulse();
    flush = 1'b1;
    if (m_cnt > 0) model_flush();
    tick();
    flush = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && exp_q.size() > 0; i++) tick();
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d bytes still expected, expected 0", exp_q.size());
    end
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    tests++;
    if (bv !== 1'b0 || byte_o !== 8'h00 || wr_if.WrReadyOut !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs: got v=%b b=%h rdy=%b busy=%b, expected 0 00 0 0",
               bv, byte_o, wr_if.WrReadyOut, busy);
    end
    rst = 1'b0;
    tick();
    tests++;
    if (wr_if.WrReadyOut !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: got rdy=%b busy=%b, expected 1 0", wr_if.WrReadyOut, busy);
    end
    // A flush with an empty buffer must be ignored.
    flush_pulse();
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (busy !== 1'b0) begin
        fails++;
        $display("FAIL empty_flush: got busy=%b, expected 0", busy);
      end
    end
  endtask

  task automatic test_explicit_flush();
    write_byte(18'h12345, 8'hAA);
    write_byte(18'h12346, 8'hBB);
    write_byte(18'h12347, 8'hCC);
    flush_pulse();
    tests++;
    if (bv !== 1'b1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL flush_latency: got v=%b busy=%b, expected 1 1", bv, busy);
    end
    for (int i = 0; i < 9; i++) begin
      tests++;
      if (wr_if.WrReadyOut !== 1'b0) begin
        fails++;
        $display("FAIL ready_low: cycle %0d got rdy=%b, expected 0", i, wr_if.WrReadyOut);
      end
      flush = (i == 2);
      tick();
      flush = 1'b0;
    end
    tests++;
    if (wr_if.WrReadyOut !== 1'b1 || bv !== 1'b0) begin
      fails++;
      $display("FAIL ready_return: got rdy=%b v=%b, expected 1 0", wr_if.WrReadyOut, bv);
    end
    drain();
  endtask

  task automatic test_timeout();
    write_byte(18'h12348, 8'h5A);
    write_byte(18'h12349, 8'hA5);
    model_flush();
    for (int i = 0; i < IT - 1; i++) begin
      tick();
      tests++;
      if (bv !== 1'b0) begin
        fails++;
        $display("FAIL timeout_early: idle cycle %0d got v=%b, expected 0", i, bv);
      end
    end
    tick();
    tests++;
    if (bv !== 1'b1) begin
      fails++;
      $display("FAIL timeout_start: got v=%b, expected 1", bv);
    end
    drain();
  endtask

  task automatic test_full_burst();
    for (int i = 0; i < BL; i++) write_byte(18'h00010 + AW'(i), 8'(8'h30 + i));
    drain();
    // Tracked pointer is now 0x00020: a write there needs no SetAddr.
    write_byte(18'h00020, 8'h77);
    flush_pulse();
    drain();
  endtask

  task automatic test_noncontig();
    write_byte(18'h00100, 8'h11);
    write_byte(18'h00101, 8'h22);
    write_byte(18'h00200, 8'h33);
    flush_pulse();
    drain();
  endtask

  task automatic test_wrap();
    write_byte(18'h3FFFF, 8'hE1);
    write_byte(18'h00000, 8'hE2);
    flush_pulse();
    drain();
    write_byte(18'h00001, 8'hE3);
    flush_pulse();
    drain();
  endtask

  task automatic test_reset_mid_burst();
    write_byte(18'h00500, 8'h51);
    write_byte(18'h00501, 8'h52);
    write_byte(18'h00502, 8'h53);
    write_byte(18'h00503, 8'h54);
    // Only the prefix up to the first data byte is emitted before reset.
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h05);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h10);
    exp_q.push_back(8'h03);
    exp_q.push_back(8'h51);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    rst = 1'b1;
    tick();
    tests++;
    if (bv !== 1'b0 || wr_if.WrReadyOut !== 1'b0 || busy !== 1'b0 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL mid_reset: got v=%b rdy=%b busy=%b left=%0d, expected 0 0 0 0",
               bv, wr_if.WrReadyOut, busy, exp_q.size());
    end
    rst = 1'b0;
    m_cnt = 0;
    m_tv  = 1'b0;
    tick();
    tests++;
    if (wr_if.WrReadyOut !== 1'b1) begin
      fails++;
      $display("FAIL mid_reset_ready: got rdy=%b, expected 1", wr_if.WrReadyOut);
    end
    write_byte(18'h00001, 8'h99);
    flush_pulse();
    drain();
  endtask

  initial begin
    rst             = 1'b1;
    flush           = 1'b0;
    wr_if.WrValidIn = 1'b0;
    wr_if.WrAddrIn  = '0;
    wr_if.WrDataIn  = 8'h00;
    m_run           = '0;
    m_track         = '0;
    m_tv            = 1'b0;
    m_cnt           = 0;
    test_reset();
    test_explicit_flush();
    test_timeout();
    test_full_burst();
    test_noncontig();
    test_wrap();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
